as_mac_lut_arbiter: RTL and testbench

Shares the single anti-spoof MAC LUT memory port between two requesters: the register-block read/write port (level handshake, ack held until req drops) and the datapath MAC-learning port. Learning writes are read-checked first and dropped if the target entry is write-protected. Round-robin arbitration, per-access timeout, drop/timeout counters. Sits between as_op_lut_regs / learning logic and the LUT/CAM storage.

---
 rtl/as_mac_lut_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_as_mac_lut_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as_mac_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : as_mac_lut_arbiter
// Brief    : Round-robin arbiter for the anti-spoof MAC LUT port. It serves the
//            register read/write port and the MAC-learning port, and learning
//            writes are dropped when the target entry is write-protected.
// Revision : 1.0 - initial release
// ============================================================================
module as_mac_lut_arbiter #(
    parameter int NUM_OUTPUT_QUEUES = 5,
    parameter int LUT_DEPTH_BITS    = 4,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    // register read port
    input  logic                              reg_rd_req,
    input  logic [LUT_DEPTH_BITS-1:0]         reg_rd_addr,
    output logic [NUM_OUTPUT_QUEUES-1:0]      reg_rd_oq,
    output logic                              reg_rd_wr_protect,
    output logic [47:0]                       reg_rd_mac,
    output logic                              reg_rd_ack,
    // register write port
    input  logic                              reg_wr_req,
    input  logic [LUT_DEPTH_BITS-1:0]         reg_wr_addr,
    input  logic [NUM_OUTPUT_QUEUES-1:0]      reg_wr_oq,
    input  logic                              reg_wr_protect,
    input  logic [47:0]                       reg_wr_mac,
    output logic                              reg_wr_ack,
    // learning port
    input  logic                              lrn_req,
    input  logic [LUT_DEPTH_BITS-1:0]         lrn_addr,
    input  logic [NUM_OUTPUT_QUEUES-1:0]      lrn_oq,
    input  logic [47:0]                       lrn_mac,
    output logic                              lrn_done,
    output logic                              lrn_dropped,
    // LUT memory port
    output logic                              lut_req,
    output logic                              lut_we,
    output logic [LUT_DEPTH_BITS-1:0]         lut_addr,
    output logic [NUM_OUTPUT_QUEUES+48:0]     lut_wdata,
    input  logic [NUM_OUTPUT_QUEUES+48:0]     lut_rdata,
    input  logic                              lut_ack,
    // statistics
    output logic [31:0]                       num_lrn_drops,
    output logic [31:0]                       num_timeouts
);

    localparam int c_NQ       = NUM_OUTPUT_QUEUES;
    localparam int c_EW       = NUM_OUTPUT_QUEUES + 49;
    localparam int c_PROT_BIT = NUM_OUTPUT_QUEUES + 48;
    localparam int c_TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic c_RR_REG = 1'b0;
    localparam logic c_RR_LRN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REG_RD   = 3'd1,
        S_REG_WR   = 3'd2,
        S_REG_HOLD = 3'd3,
        S_LRN_CHK  = 3'd4,
        S_LRN_WR   = 3'd5,
        S_LRN_END  = 3'd6
    } state_t;

    state_t                   r_state;
    logic                     r_rr_ptr;
    logic                     r_hold_rd;
    logic [c_TMO_W-1:0]       r_tmo_cnt;
    logic [c_NQ-1:0]          r_lrn_oq;
    logic [47:0]              r_lrn_mac;
    logic                     r_lut_req;
    logic                     r_lut_we;
    logic [LUT_DEPTH_BITS-1:0] r_lut_addr;
    logic [c_EW-1:0]          r_lut_wdata;
    logic [c_NQ-1:0]          r_reg_rd_oq;
    logic                     r_reg_rd_prot;
    logic [47:0]              r_reg_rd_mac;
    logic                     r_reg_rd_ack;
    logic                     r_reg_wr_ack;
    logic                     r_lrn_done;
    logic                     r_lrn_dropped;
    logic [31:0]              r_num_lrn_drops;
    logic [31:0]              r_num_timeouts;

    logic w_reg_req;
    logic w_grant_reg;
    logic w_tmo;
    logic w_hold_release;

    assign w_reg_req      = reg_rd_req | reg_wr_req;
    assign w_grant_reg    = w_reg_req & (~lrn_req | (r_rr_ptr == c_RR_REG));
    // Expiry only counts while a request is outstanding and no ack arrives.
    assign w_tmo          = r_lut_req & ~lut_ack & (r_tmo_cnt == c_TMO_LAST);
    assign w_hold_release = r_hold_rd ? ~reg_rd_req : ~reg_wr_req;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= c_RR_REG;
            r_hold_rd       <= 1'b0;
            r_tmo_cnt       <= '0;
            r_lrn_oq        <= '0;
            r_lrn_mac       <= '0;
            r_lut_req       <= 1'b0;
            r_lut_we        <= 1'b0;
            r_lut_addr      <= '0;
            r_lut_wdata     <= '0;
            r_reg_rd_oq     <= '0;
            r_reg_rd_prot   <= 1'b0;
            r_reg_rd_mac    <= '0;
            r_reg_rd_ack    <= 1'b0;
            r_reg_wr_ack    <= 1'b0;
            r_lrn_done      <= 1'b0;
            r_lrn_dropped   <= 1'b0;
            r_num_lrn_drops <= '0;
            r_num_timeouts  <= '0;
        end else begin
            r_lrn_done    <= 1'b0;
            r_lrn_dropped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_reg) begin
                        r_rr_ptr  <= c_RR_LRN;
                        r_tmo_cnt <= '0;
                        r_lut_req <= 1'b1;
                        if (reg_rd_req) begin
                            r_state     <= S_REG_RD;
                            r_hold_rd   <= 1'b1;
                            r_lut_we    <= 1'b0;
                            r_lut_addr  <= reg_rd_addr;
                            r_lut_wdata <= '0;
                        end else begin
                            r_state     <= S_REG_WR;
                            r_hold_rd   <= 1'b0;
                            r_lut_we    <= 1'b1;
                            r_lut_addr  <= reg_wr_addr;
                            r_lut_wdata <= {reg_wr_protect, reg_wr_oq, reg_wr_mac};
                        end
                    end else if (lrn_req) begin
                        r_rr_ptr    <= c_RR_REG;
                        r_tmo_cnt   <= '0;
                        r_lut_req   <= 1'b1;
                        r_lut_we    <= 1'b0;
                        r_lut_addr  <= lrn_addr;
                        r_lut_wdata <= '0;
                        r_lrn_oq    <= lrn_oq;
                        r_lrn_mac   <= lrn_mac;
                        r_state     <= S_LRN_CHK;
                    end
                end

                S_REG_RD, S_REG_WR: begin
                    if (lut_ack) begin
                        r_lut_req <= 1'b0;
                        r_state   <= S_REG_HOLD;
                        if (r_state == S_REG_RD) begin
                            r_reg_rd_oq   <= lut_rdata[c_PROT_BIT-1:48];
                            r_reg_rd_prot <= lut_rdata[c_PROT_BIT];
                            r_reg_rd_mac  <= lut_rdata[47:0];
                            r_reg_rd_ack  <= 1'b1;
                        end else begin
                            r_reg_wr_ack  <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        // Aborted accesses still complete the handshake; reads return all ones.
                        r_lut_req      <= 1'b0;
                        r_num_timeouts <= sat_inc(r_num_timeouts);
                        r_state        <= S_REG_HOLD;
                        if (r_state == S_REG_RD) begin
                            r_reg_rd_oq   <= '1;
                            r_reg_rd_prot <= 1'b1;
                            r_reg_rd_mac  <= '1;
                            r_reg_rd_ack  <= 1'b1;
                        end else begin
                            r_reg_wr_ack  <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_REG_HOLD: begin
                    if (w_hold_release) begin
                        r_reg_rd_ack <= 1'b0;
                        r_reg_wr_ack <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                S_LRN_CHK: begin
                    if (lut_ack) begin
                        r_lut_req <= 1'b0;
                        if (lut_rdata[c_PROT_BIT]) begin
                            r_num_lrn_drops <= sat_inc(r_num_lrn_drops);
                            r_lrn_done      <= 1'b1;
                            r_lrn_dropped   <= 1'b1;
                            r_state         <= S_LRN_END;
                        end else begin
                            r_state         <= S_LRN_WR;
                        end
                    end else if (w_tmo) begin
                        r_lut_req      <= 1'b0;
                        r_num_timeouts <= sat_inc(r_num_timeouts);
                        r_lrn_done     <= 1'b1;
                        r_lrn_dropped  <= 1'b1;
                        r_state        <= S_LRN_END;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_LRN_WR: begin
                    // lut_req is low for one cycle between the check read and this write.
                    if (!r_lut_req) begin
                        r_lut_req   <= 1'b1;
                        r_lut_we    <= 1'b1;
                        r_lut_wdata <= {1'b0, r_lrn_oq, r_lrn_mac};
                        r_tmo_cnt   <= '0;
                    end else if (lut_ack) begin
                        r_lut_req  <= 1'b0;
                        r_lrn_done <= 1'b1;
                        r_state    <= S_LRN_END;
                    end else if (w_tmo) begin
                        r_lut_req      <= 1'b0;
                        r_num_timeouts <= sat_inc(r_num_timeouts);
                        r_lrn_done     <= 1'b1;
                        r_lrn_dropped  <= 1'b1;
                        r_state        <= S_LRN_END;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_LRN_END: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_lut_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign reg_rd_oq         = r_reg_rd_oq;
    assign reg_rd_wr_protect = r_reg_rd_prot;
    assign reg_rd_mac        = r_reg_rd_mac;
    assign reg_rd_ack        = r_reg_rd_ack;
    assign reg_wr_ack        = r_reg_wr_ack;
    assign lrn_done          = r_lrn_done;
    assign lrn_dropped       = r_lrn_dropped;
    assign lut_req           = r_lut_req;
    assign lut_we            = r_lut_we;
    assign lut_addr          = r_lut_addr;
    assign lut_wdata         = r_lut_wdata;
    assign num_lrn_drops     = r_num_lrn_drops;
    assign num_timeouts      = r_num_timeouts;

endmodule
`default_nettype wire

// File: tb/tb_as_mac_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_as_mac_lut_arbiter
// Brief    : Directed, table-driven bench for as_mac_lut_arbiter with a
//            behavioural LUT responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_as_mac_lut_arbiter;

    localparam int c_NQ  = 5;
    localparam int c_LDB = 4;
    localparam int c_EW  = c_NQ + 49;
    localparam logic [1:0] c_OP_WR  = 2'd0;
    localparam logic [1:0] c_OP_RD  = 2'd1;
    localparam logic [1:0] c_OP_LRN = 2'd2;

    logic              clk;
    logic              reset_n;
    logic              reg_rd_req;
    logic [c_LDB-1:0]  reg_rd_addr;
    logic [c_NQ-1:0]   reg_rd_oq;
    logic              reg_rd_wr_protect;
    logic [47:0]       reg_rd_mac;
    logic              reg_rd_ack;
    logic              reg_wr_req;
    logic [c_LDB-1:0]  reg_wr_addr;
    logic [c_NQ-1:0]   reg_wr_oq;
    logic              reg_wr_protect;
    logic [47:0]       reg_wr_mac;
    logic              reg_wr_ack;
    logic              lrn_req;
    logic [c_LDB-1:0]  lrn_addr;
    logic [c_NQ-1:0]   lrn_oq;
    logic [47:0]       lrn_mac;
    logic              lrn_done;
    logic              lrn_dropped;
    logic              lut_req;
    logic              lut_we;
    logic [c_LDB-1:0]  lut_addr;
    logic [c_EW-1:0]   lut_wdata;
    logic [c_EW-1:0]   lut_rdata;
    logic              lut_ack;
    logic [31:0]       num_lrn_drops;
    logic [31:0]       num_timeouts;

    as_mac_lut_arbiter #(
        .NUM_OUTPUT_QUEUES (c_NQ),
        .LUT_DEPTH_BITS    (c_LDB),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .reg_rd_req        (reg_rd_req),
        .reg_rd_addr       (reg_rd_addr),
        .reg_rd_oq         (reg_rd_oq),
        .reg_rd_wr_protect (reg_rd_wr_protect),
        .reg_rd_mac        (reg_rd_mac),
        .reg_rd_ack        (reg_rd_ack),
        .reg_wr_req        (reg_wr_req),
        .reg_wr_addr       (reg_wr_addr),
        .reg_wr_oq         (reg_wr_oq),
        .reg_wr_protect    (reg_wr_protect),
        .reg_wr_mac        (reg_wr_mac),
        .reg_wr_ack        (reg_wr_ack),
        .lrn_req           (lrn_req),
        .lrn_addr          (lrn_addr),
        .lrn_oq            (lrn_oq),
        .lrn_mac           (lrn_mac),
        .lrn_done          (lrn_done),
        .lrn_dropped       (lrn_dropped),
        .lut_req           (lut_req),
        .lut_we            (lut_we),
        .lut_addr          (lut_addr),
        .lut_wdata         (lut_wdata),
        .lut_rdata         (lut_rdata),
        .lut_ack           (lut_ack),
        .num_lrn_drops     (num_lrn_drops),
        .num_timeouts      (num_timeouts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // LUT model and access log
    logic [c_EW-1:0]  mem [16];
    logic [c_EW-1:0]  last_wdata;
    logic [c_LDB-1:0] rd_log [8];
    int ack_delay;
    int run_len;
    int last_run;
    int log_n;
    int n_rd;
    int n_wr;
    int n_checks;
    int n_err;

    initial begin
        lut_ack    = 1'b0;
        lut_rdata  = '0;
        last_wdata = '0;
        run_len    = 0;
        last_run   = 0;
        n_rd       = 0;
        n_wr       = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) rd_log[i] = '0;
        forever begin
            @(negedge clk);
            lut_ack = 1'b0;
            if (!reset_n || !lut_req) begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end else begin
                run_len++;
                if (run_len == 1 && !lut_we) begin
                    if (log_n < 8) rd_log[log_n] = lut_addr;
                    log_n++;
                end
                if (ack_delay != 0 && run_len == ack_delay) begin
                    lut_ack   = 1'b1;
                    lut_rdata = mem[lut_addr];
                    if (lut_we) begin
                        mem[lut_addr] = lut_wdata;
                        last_wdata    = lut_wdata;
                        n_wr++;
                    end else begin
                        n_rd++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [c_LDB-1:0] a, input logic [c_NQ-1:0] oq,
                          input logic p, input logic [47:0] mac);
        int got;
        got = 0;
        reg_wr_addr = a; reg_wr_oq = oq; reg_wr_protect = p; reg_wr_mac = mac;
        reg_wr_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (reg_wr_ack) begin got = 1; break; end
        end
        chk("wr_ack_seen", 64'(got), 64'd1);
        tick(); tick();
        chk("wr_ack_held", 64'(reg_wr_ack), 64'd1);
        reg_wr_req = 1'b0;
        tick();
        chk("wr_ack_release", 64'(reg_wr_ack), 64'd0);
    endtask

    task automatic reg_rd(input logic [c_LDB-1:0] a, output logic [c_NQ-1:0] oq,
                          output logic p, output logic [47:0] mac);
        int got;
        got = 0;
        reg_rd_addr = a;
        reg_rd_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (reg_rd_ack) begin got = 1; break; end
        end
        chk("rd_ack_seen", 64'(got), 64'd1);
        oq = reg_rd_oq; p = reg_rd_wr_protect; mac = reg_rd_mac;
        tick(); tick();
        chk("rd_ack_held", 64'(reg_rd_ack), 64'd1);
        reg_rd_req = 1'b0;
        tick();
        chk("rd_ack_release", 64'(reg_rd_ack), 64'd0);
    endtask

    task automatic lrn(input logic [c_LDB-1:0] a, input logic [c_NQ-1:0] oq,
                       input logic [47:0] mac, output logic dropped);
        int got;
        got = 0;
        dropped  = 1'b0;
        lrn_addr = a; lrn_oq = oq; lrn_mac = mac;
        lrn_req  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (lrn_done) begin got = 1; break; end
        end
        chk("lrn_done_seen", 64'(got), 64'd1);
        dropped = lrn_dropped;
        lrn_req = 1'b0;
        tick();
        chk("lrn_done_pulse", 64'(lrn_done), 64'd0);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [c_LDB-1:0] addr;
        logic [c_NQ-1:0]  oq;
        logic             prot;
        logic [47:0]      mac;
        logic [c_NQ-1:0]  e_oq;
        logic             e_prot;
        logic [47:0]      e_mac;
        logic             e_drop;
        int               e_drd;
        int               e_dwr;
        logic [c_EW-1:0]  e_wdata;
        int               e_drops;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [c_NQ-1:0] g_oq;
        logic            g_prot;
        logic [47:0]     g_mac;
        logic            g_drop;
        int              rd0, wr0, got;

        vecs[0] = '{c_OP_WR,  4'd3, 5'h04, 1'b1, 48'h0011_2233_4455, 5'h00, 1'b0, 48'h0, 1'b0, 0, 1,
                    {1'b1, 5'h04, 48'h0011_2233_4455}, 0};
        vecs[1] = '{c_OP_RD,  4'd3, 5'h00, 1'b0, 48'h0, 5'h04, 1'b1, 48'h0011_2233_4455, 1'b0, 1, 0, '0, 0};
        vecs[2] = '{c_OP_LRN, 4'd3, 5'h1F, 1'b0, 48'hAABB_CCDD_EEFF, 5'h00, 1'b0, 48'h0, 1'b1, 1, 0, '0, 1};
        vecs[3] = '{c_OP_LRN, 4'd7, 5'h0A, 1'b0, 48'h0000_1234_5678, 5'h00, 1'b0, 48'h0, 1'b0, 1, 1,
                    {1'b0, 5'h0A, 48'h0000_1234_5678}, 1};
        vecs[4] = '{c_OP_RD,  4'd7, 5'h00, 1'b0, 48'h0, 5'h0A, 1'b0, 48'h0000_1234_5678, 1'b0, 1, 0, '0, 1};
        vecs[5] = '{c_OP_WR,  4'd0, 5'h1F, 1'b0, 48'hFFFF_0000_FFFF, 5'h00, 1'b0, 48'h0, 1'b0, 0, 1,
                    {1'b0, 5'h1F, 48'hFFFF_0000_FFFF}, 1};
        vecs[6] = '{c_OP_RD,  4'd0, 5'h00, 1'b0, 48'h0, 5'h1F, 1'b0, 48'hFFFF_0000_FFFF, 1'b0, 1, 0, '0, 1};

        n_checks = 0; n_err = 0; log_n = 0; ack_delay = 2;
        reset_n = 1'b0;
        reg_rd_req = 1'b0; reg_rd_addr = '0;
        reg_wr_req = 1'b0; reg_wr_addr = '0; reg_wr_oq = '0; reg_wr_protect = 1'b0; reg_wr_mac = '0;
        lrn_req = 1'b0; lrn_addr = '0; lrn_oq = '0; lrn_mac = '0;
        tick(); tick();
        chk("rst_lut_req", 64'(lut_req), 64'd0);
        chk("rst_lut_wdata", 64'(lut_wdata), 64'd0);
        chk("rst_rd_ack", 64'(reg_rd_ack), 64'd0);
        chk("rst_wr_ack", 64'(reg_wr_ack), 64'd0);
        chk("rst_lrn_done", 64'(lrn_done), 64'd0);
        chk("rst_counters", {num_lrn_drops, num_timeouts}, 64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            rd0 = n_rd; wr0 = n_wr;
            case (vecs[i].op)
                c_OP_WR: reg_wr(vecs[i].addr, vecs[i].oq, vecs[i].prot, vecs[i].mac);
                c_OP_RD: begin
                    reg_rd(vecs[i].addr, g_oq, g_prot, g_mac);
                    chk($sformatf("v%0d_rd_oq", i), 64'(g_oq), 64'(vecs[i].e_oq));
                    chk($sformatf("v%0d_rd_prot", i), 64'(g_prot), 64'(vecs[i].e_prot));
                    chk($sformatf("v%0d_rd_mac", i), 64'(g_mac), 64'(vecs[i].e_mac));
                end
                default: begin
                    lrn(vecs[i].addr, vecs[i].oq, vecs[i].mac, g_drop);
                    chk($sformatf("v%0d_lrn_dropped", i), 64'(g_drop), 64'(vecs[i].e_drop));
                    chk($sformatf("v%0d_lrn_drops", i), 64'(num_lrn_drops), 64'(vecs[i].e_drops));
                end
            endcase
            chk($sformatf("v%0d_lut_reads", i), 64'(n_rd - rd0), 64'(vecs[i].e_drd));
            chk($sformatf("v%0d_lut_writes", i), 64'(n_wr - wr0), 64'(vecs[i].e_dwr));
            if (vecs[i].e_dwr != 0)
                chk($sformatf("v%0d_lut_wdata", i), 64'(last_wdata), 64'(vecs[i].e_wdata));
        end

        // Write request withdrawn mid-access: write completes, ack pulses once.
        ack_delay = 4;
        wr0 = n_wr;
        reg_wr_addr = 4'd5; reg_wr_oq = 5'h13; reg_wr_protect = 1'b1; reg_wr_mac = 48'hDEAD_BEEF_0001;
        reg_wr_req = 1'b1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lut_req) begin got = 1; break; end
        end
        chk("wdrop_lut_req", 64'(got), 64'd1);
        tick();
        reg_wr_req = 1'b0;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (reg_wr_ack) begin got = 1; break; end
        end
        chk("wdrop_ack", 64'(got), 64'd1);
        tick();
        chk("wdrop_ack_pulse", 64'(reg_wr_ack), 64'd0);
        chk("wdrop_mem", 64'(mem[5]), 64'({1'b1, 5'h13, 48'hDEAD_BEEF_0001}));
        chk("wdrop_writes", 64'(n_wr - wr0), 64'd1);

        // Both sides requesting from reset: grants alternate REG, LRN, REG, LRN.
        ack_delay = 2;
        reset_n = 1'b0;
        reg_rd_addr = 4'd3; reg_rd_req = 1'b1;
        lrn_addr = 4'd7; lrn_oq = 5'h01; lrn_mac = 48'h0000_0000_0777; lrn_req = 1'b1;
        tick();
        log_n = 0;
        reset_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            reg_rd_req = ~reg_rd_ack;
            if (log_n >= 4) break;
        end
        chk("alt_count", 64'(log_n >= 4), 64'd1);
        chk("alt_0", 64'(rd_log[0]), 64'd3);
        chk("alt_1", 64'(rd_log[1]), 64'd7);
        chk("alt_2", 64'(rd_log[2]), 64'd3);
        chk("alt_3", 64'(rd_log[3]), 64'd7);
        reset_n = 1'b0; reg_rd_req = 1'b0; lrn_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // LUT never answers: register read times out after 16 cycles.
        ack_delay = 0;
        reg_rd(4'd3, g_oq, g_prot, g_mac);
        chk("tmo_req_cycles", 64'(last_run), 64'd16);
        chk("tmo_count", 64'(num_timeouts), 64'd1);
        chk("tmo_rd_mac", 64'(g_mac), 64'hFFFF_FFFF_FFFF);
        chk("tmo_rd_prot", 64'(g_prot), 64'd1);
        chk("tmo_rd_oq", 64'(g_oq), 64'h1F);

        // Learn timeout: dropped, but not counted as a protect drop.
        wr0 = n_wr;
        lrn(4'd9, 5'h03, 48'h1, g_drop);
        chk("ltmo_dropped", 64'(g_drop), 64'd1);
        chk("ltmo_count", 64'(num_timeouts), 64'd2);
        chk("ltmo_drops", 64'(num_lrn_drops), 64'd0);
        chk("ltmo_writes", 64'(n_wr - wr0), 64'd0);

        // Asynchronous reset in the middle of an access.
        reg_rd_addr = 4'd2; reg_rd_req = 1'b1;
        tick(); tick(); tick(); tick();
        chk("arst_pre_req", 64'(lut_req), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_lut_req", 64'(lut_req), 64'd0);
        chk("arst_lut_addr", 64'(lut_addr), 64'd0);
        chk("arst_rd_ack", 64'(reg_rd_ack), 64'd0);
        chk("arst_rd_mac", 64'(reg_rd_mac), 64'd0);
        chk("arst_timeouts", 64'(num_timeouts), 64'd0);
        reg_rd_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("arst_idle_req", 64'(lut_req), 64'd0);
        chk("arst_idle_ack", 64'(reg_rd_ack), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
